// File: rtl/rv32m_pkg.sv
// rtl/rv32m_pkg.sv - RV32M divide encodings shared by the decoder, hazard unit and divider
package rv32m_pkg;

  typedef enum logic [1:0] {
    FUNCT_DIV  = 2'b00,
    FUNCT_DIVU = 2'b01,
    FUNCT_REM  = 2'b10,
    FUNCT_REMU = 2'b11
  } funct_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIN  = 2'b10
  } state_e;

  localparam int DIV_STEPS = 32;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/div_step_32bit.sv
// rtl/div_step_32bit.sv - one radix-2 restoring division step (combinational)
module div_step_32bit (
  input  logic [32:0] rem_i,
  input  logic [31:0] quot_i,
  input  logic [31:0] dvs_i,
  output logic [32:0] rem_o,
  output logic [31:0] quot_o,
  output logic        q_bit_o
);

  logic [33:0] shifted;
  logic [33:0] diff;

  always_comb begin
    shifted = {rem_i, quot_i[31]};
    diff    = shifted - {2'b00, dvs_i};
    // A clear sign bit means the divisor fit, so the difference is kept.
    q_bit_o = ~diff[33];
    rem_o   = q_bit_o ? diff[32:0] : shifted[32:0];
    quot_o  = {quot_i[30:0], 1'b0};
  end

endmodule

// File: rtl/div_unit_32bit.sv
// rtl/div_unit_32bit.sv - iterative RV32M DIV/DIVU/REM/REMU unit, 32 restoring steps
module div_unit_32bit
  import rv32m_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             START,
  input  logic [1:0]       FUNCT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic             FLUSH,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT
);

  state_e      state_q, state_d;
  funct_e      funct_q, funct_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] dvs_q, dvs_d;
  logic [32:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        qsign_q, qsign_d;
  logic        rsign_q, rsign_d;
  logic [31:0] result_q, result_d;

  logic [32:0] step_rem;
  logic [31:0] step_quot;
  logic        step_qbit;
  logic [31:0] quot_next;
  logic        in_signed;
  logic        in_is_rem;
  logic        in_ovf;

  div_step_32bit u_step (
    .rem_i   (rem_q),
    .quot_i  (quot_q),
    .dvs_i   (dvs_q),
    .rem_o   (step_rem),
    .quot_o  (step_quot),
    .q_bit_o (step_qbit)
  );

  always_comb begin
    state_d   = state_q;
    funct_d   = funct_q;
    quot_d    = quot_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    qsign_d   = qsign_q;
    rsign_d   = rsign_q;
    result_d  = result_q;
    in_signed = (funct_e'(FUNCT) == FUNCT_DIV) || (funct_e'(FUNCT) == FUNCT_REM);
    in_is_rem = FUNCT[1];
    in_ovf    = in_signed && (DATA1 == 32'h8000_0000) && (DATA2 == 32'hFFFF_FFFF);
    quot_next = step_quot | {31'd0, step_qbit};

    case (state_q)
      ST_IDLE: begin
        if (START && !FLUSH) begin
          if (DATA2 == 32'd0) begin
            state_d  = ST_FIN;
            result_d = in_is_rem ? DATA1 : 32'hFFFF_FFFF;
          end else if (in_ovf) begin
            state_d  = ST_FIN;
            result_d = in_is_rem ? 32'd0 : 32'h8000_0000;
          end else begin
            state_d = ST_CALC;
            funct_d = funct_e'(FUNCT);
            quot_d  = (in_signed && DATA1[31]) ? neg32(DATA1) : DATA1;
            dvs_d   = (in_signed && DATA2[31]) ? neg32(DATA2) : DATA2;
            qsign_d = in_signed && (DATA1[31] ^ DATA2[31]);
            rsign_d = in_signed && DATA1[31];
            rem_d   = 33'd0;
            cnt_d   = 5'd0;
          end
        end
      end
      ST_CALC: begin
        if (FLUSH) begin
          state_d = ST_IDLE;
        end else begin
          rem_d  = step_rem;
          quot_d = quot_next;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'(DIV_STEPS - 1)) begin
            state_d = ST_FIN;
            // Sign fix-up happens on the same edge the last quotient bit lands.
            if (funct_q[1]) begin
              result_d = rsign_q ? neg32(step_rem[31:0]) : step_rem[31:0];
            end else begin
              result_d = qsign_q ? neg32(quot_next) : quot_next;
            end
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= ST_IDLE;
      funct_q  <= FUNCT_DIV;
      quot_q   <= 32'd0;
      dvs_q    <= 32'd0;
      rem_q    <= 33'd0;
      cnt_q    <= 5'd0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      funct_q  <= funct_d;
      quot_q   <= quot_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      result_q <= result_d;
    end
  end

  assign BUSY   = (state_q != ST_IDLE);
  assign DONE   = (state_q == ST_FIN);
  assign RESULT = result_q;

endmodule

// File: tb/tb_div_unit_32bit.sv
// tb/tb_div_unit_32bit.sv - self-checking bench for div_unit_32bit against an arithmetic model
module tb_div_unit_32bit;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        START;
  logic [1:0]  FUNCT;
  logic [31:0] DATA1;
  logic [31:0] DATA2;
  logic        FLUSH;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  div_unit_32bit #(.WIDTH(32)) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .START  (START),
    .FUNCT  (FUNCT),
    .DATA1  (DATA1),
    .DATA2  (DATA2),
    .FLUSH  (FLUSH),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .RESULT (RESULT)
  );

  // RISC-V M-extension division semantics in plain arithmetic.
  function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = int'(a);
    sb = int'(b);
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : 32'h8000_0000;
    case (f)
      2'b00:   return 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int model_latency(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issues START in cycle 0 and returns the cycle DONE is seen (-1 if never) plus RESULT then.
  task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res);
    @(negedge CLK);
    START = 1'b1; FUNCT = f; DATA1 = a; DATA2 = b;
    @(negedge CLK);
    START = 1'b0;
    lat = -1;
    res = 32'hDEAD_BEEF;
    for (int c = 1; c <= 40; c++) begin
      if (DONE) begin
        lat = c;
        res = RESULT;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RESETN = 1'b0;
    repeat (2) @(negedge CLK);
    n_tests++;
    if ({BUSY, DONE, RESULT} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_state busy=%b done=%b result=%h required 0 0 00000000", BUSY, DONE, RESULT);
    end
    RESETN = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_directed();
    logic [1:0]  tf [8] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b01, 2'b10, 2'b00, 2'b10};
    logic [31:0] ta [8] = '{32'h14, 32'hFFFFFFEC, 32'hFFFFFFEC, 32'hFFFFFFFF,
                            32'h1234, 32'h1234, 32'h80000000, 32'h80000000};
    logic [31:0] tb [8] = '{32'hFFFFFFFD, 32'h3, 32'h3, 32'h2, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] te [8] = '{32'hFFFFFFFA, 32'hFFFFFFFE, 32'h2, 32'h7FFFFFFF,
                            32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'h0};
    int          tl [8] = '{33, 33, 33, 33, 1, 1, 1, 1};
    int          lat;
    logic [31:0] res;
    for (int i = 0; i < 8; i++) begin
      run_op(tf[i], ta[i], tb[i], lat, res);
      n_tests++;
      if (res !== te[i] || lat != tl[i]) begin
        n_fail++;
        $display("FAIL directed_%0d result=%h cycle=%0d required %h cycle %0d", i, res, lat, te[i], tl[i]);
      end
      @(negedge CLK);
      n_tests++;
      if (BUSY !== 1'b0 || DONE !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_%0d_idle busy=%b done=%b required 0 0", i, BUSY, DONE);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] res;
    for (int i = 0; i < 40; i++) begin
      f = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: b = -32'($urandom_range(1, 9));
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4: a = 32'($urandom_range(0, 50));
        default: ;
      endcase
      // Back-to-back: the next START lands in the cycle right after DONE.
      run_op(f, a, b, lat, res);
      n_tests++;
      if (res !== model(f, a, b) || lat != model_latency(f, a, b)) begin
        n_fail++;
        $display("FAIL random_%0d f=%0d a=%h b=%h result=%h cycle=%0d required %h cycle %0d",
                 i, f, a, b, res, lat, model(f, a, b), model_latency(f, a, b));
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    int          lat;
    logic [31:0] res;
    bit          done_seen;
    prev = RESULT;
    done_seen = 0;
    @(negedge CLK);
    START = 1'b1; FUNCT = 2'b00; DATA1 = 32'd1000; DATA2 = 32'd7;
    @(negedge CLK);
    START = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (DONE) done_seen = 1;
      @(negedge CLK);
    end
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    n_tests++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || done_seen || RESULT !== prev) begin
      n_fail++;
      $display("FAIL flush busy=%b done=%b result=%h required 0 0 %h", BUSY, DONE, RESULT, prev);
    end
    run_op(2'b01, 32'd1000, 32'd7, lat, res);
    n_tests++;
    if (res !== 32'd142 || lat != 33) begin
      n_fail++;
      $display("FAIL flush_restart result=%h cycle=%0d required 0000008e cycle 33", res, lat);
    end
  endtask

  task automatic test_ignored_start();
    int          lat;
    logic [31:0] res;
    lat = -1;
    res = 32'hDEAD_BEEF;
    @(negedge CLK);
    START = 1'b1; FUNCT = 2'b01; DATA1 = 32'd123456; DATA2 = 32'd10;
    @(negedge CLK);
    START = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 5) begin
        START = 1'b1; FUNCT = 2'b10; DATA1 = 32'hFFFF_0000; DATA2 = 32'd3;
      end else begin
        START = 1'b0;
      end
      if (DONE) begin
        lat = c;
        res = RESULT;
        break;
      end
      @(negedge CLK);
    end
    START = 1'b0;
    n_tests++;
    if (res !== model(2'b01, 32'd123456, 32'd10) || lat != 33) begin
      n_fail++;
      $display("FAIL ignored_start result=%h cycle=%0d required %h cycle 33",
               res, lat, model(2'b01, 32'd123456, 32'd10));
    end
  endtask

  task automatic test_midop_reset();
    bit done_seen;
    done_seen = 0;
    @(negedge CLK);
    START = 1'b1; FUNCT = 2'b00; DATA1 = 32'd99; DATA2 = 32'd4;
    @(negedge CLK);
    START = 1'b0;
    repeat (19) @(negedge CLK);
    RESETN = 1'b0;
    #1;
    n_tests++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || RESULT !== 32'd0) begin
      n_fail++;
      $display("FAIL midop_reset busy=%b done=%b result=%h required 0 0 00000000", BUSY, DONE, RESULT);
    end
    @(negedge CLK);
    RESETN = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (DONE || BUSY) done_seen = 1;
    end
    n_tests++;
    if (done_seen) begin
      n_fail++;
      $display("FAIL midop_resume activity_after_reset=1 required 0");
    end
  endtask

  initial begin
    RESETN = 1'b0;
    START  = 1'b0;
    FUNCT  = 2'b00;
    DATA1  = 32'd0;
    DATA2  = 32'd0;
    FLUSH  = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_ignored_start();
    test_midop_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
